pcileech_tlp_sink_arb: RTL

- Parametrised successor to the fixed three-source TLP transmit mux.
- Arbitrates NUM_PORTS buffered-TLP sources onto one 64-bit AXI-stream TLP transmit interface toward the PCIe core.
- Arbitration is round-robin or fixed-priority, with per-port enables, a grant timeout and a per-port packet counter.
- Sits in the PCIe clock domain between the TLP sources (FIFO-sourced TLPs, config-space completions, static TLPs) and the core s_axis.

---
 rtl/pcileech_tlp_sink_arb_if.sv | 31 +++
 rtl/pcileech_tlp_sink_arb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pcileech_tlp_sink_arb_if.sv
// TLP sink arbiter bus: source-port handshakes on one side, AXI-stream TX toward the core
// on the other, plus status.
interface pcileech_tlp_sink_arb_if #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned MAX_QW    = 18
);
  logic [NUM_PORTS-1:0]           port_en;
  logic [NUM_PORTS-1:0]           src_has_data;
  logic [NUM_PORTS-1:0]           src_req;
  logic [NUM_PORTS-1:0]           src_valid;
  logic [NUM_PORTS*66*MAX_QW-1:0] src_data;
  logic [63:0]                    tx_data;
  logic [7:0]                     tx_keep;
  logic                           tx_last;
  logic                           tx_valid;
  logic                           tx_ready;
  logic                           busy;
  logic [NUM_PORTS*16-1:0]        pkt_cnt;

  // Arbiter side.
  modport master (
    input  port_en, src_has_data, src_valid, src_data, tx_ready,
    output src_req, tx_data, tx_keep, tx_last, tx_valid, busy, pkt_cnt
  );

  // Sources and core side.
  modport slave (
    output port_en, src_has_data, src_valid, src_data, tx_ready,
    input  src_req, tx_data, tx_keep, tx_last, tx_valid, busy, pkt_cnt
  );
endinterface

// File: rtl/pcileech_tlp_sink_arb.sv
// Arbitrates NUM_PORTS buffered-TLP sources onto one 64-bit AXI-stream TLP transmit port,
// round-robin or fixed priority, with a grant timeout and per-port packet counters.
module pcileech_tlp_sink_arb #(
  parameter int unsigned NUM_PORTS     = 4,
  parameter int unsigned MAX_QW        = 18,
  parameter int unsigned RR_MODE       = 1,
  parameter int unsigned GRANT_TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pcileech_tlp_sink_arb_if.master bus
);

  localparam int unsigned PW = $clog2(NUM_PORTS);
  localparam int unsigned SW = $clog2(MAX_QW);

  typedef logic [65:0] slot_t;
  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic [PW-1:0]        rr_q, rr_d;
  logic [NUM_PORTS-1:0] req_q, req_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [SW-1:0]        idx_q, idx_d;
  slot_t                buf_q [MAX_QW];
  slot_t                buf_d [MAX_QW];
  logic [15:0]          cnt_q [NUM_PORTS];
  logic [15:0]          cnt_d [NUM_PORTS];

  slot_t                slot_in [NUM_PORTS][MAX_QW];
  logic [NUM_PORTS-1:0] cand;
  logic                 found;
  logic [PW-1:0]        pick;
  slot_t                head;
  logic                 last_eff;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    for (genvar s = 0; s < MAX_QW; s++) begin : g_slot
      assign slot_in[p][s] = bus.src_data[(p*MAX_QW+s)*66 +: 66];
    end
    assign bus.pkt_cnt[p*16 +: 16] = cnt_q[p];
  end

  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] g);
    return (g == PW'(NUM_PORTS-1)) ? '0 : g + 1'b1;
  endfunction

  // Candidate search starts at rr_q in round-robin mode, at 0 in fixed-priority mode.
  always_comb begin
    cand  = bus.port_en & bus.src_has_data;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      int unsigned k;
      k = (RR_MODE != 0) ? 32'(rr_q) + i : i;
      if (k >= NUM_PORTS) k = k - NUM_PORTS;
      if (!found && cand[PW'(k)]) begin
        found = 1'b1;
        pick  = PW'(k);
      end
    end
  end

  assign head = buf_q[0];
  // The final buffer slot always terminates the packet, even if its last flag is missing.
  assign last_eff = head[64] | (idx_q == SW'(MAX_QW-1));

  assign bus.tx_valid = (state_q == StSend);
  assign bus.tx_data  = head[63:0];
  assign bus.tx_last  = (state_q == StSend) & last_eff;
  assign bus.tx_keep  = (head[64] & ~head[65]) ? 8'h0f : 8'hff;
  assign bus.busy     = (state_q != StIdle);
  assign bus.src_req  = req_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    req_d   = '0;
    tmo_d   = tmo_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (found) begin
          req_d   = NUM_PORTS'(1) << pick;
          gnt_d   = pick;
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.src_valid[gnt_q]) begin
          for (int unsigned s = 0; s < MAX_QW; s++) buf_d[s] = slot_in[gnt_q][s];
          idx_d   = '0;
          state_d = StSend;
        end else if (tmo_q == 8'(GRANT_TIMEOUT)) begin
          rr_d    = next_port(gnt_q);
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StSend: begin
        if (bus.tx_ready) begin
          for (int unsigned s = 0; s < MAX_QW - 1; s++) buf_d[s] = buf_q[s+1];
          buf_d[MAX_QW-1] = '0;
          idx_d = idx_q + 1'b1;
          if (last_eff) begin
            cnt_d[gnt_q] = cnt_q[gnt_q] + 16'd1;
            rr_d         = next_port(gnt_q);
            state_d      = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      rr_q    <= '0;
      req_q   <= '0;
      tmo_q   <= '0;
      idx_q   <= '0;
      for (int unsigned s = 0; s < MAX_QW; s++) buf_q[s] <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
